// File: rtl/sequential_divider.sv
// Unsigned restoring divider: one quotient bit per clock, start/busy/done handshake.
// A zero divisor skips the calculation and flags div_zero with an all-ones quotient.
module sequential_divider #(
  parameter int WN = 8,
  parameter int WD = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [WN-1:0] dividend,
  input  logic [WD-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [WN-1:0] quotient,
  output logic [WD-1:0] remainder,
  output logic          div_zero
);

  localparam int CW = (WN > 1) ? $clog2(WN) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [WN-1:0] n_work;
  logic [WD-1:0] d_reg;
  logic [WD-1:0] r_work;
  logic [CW-1:0] cnt;
  logic [WD:0]   t_step;
  logic [WD-1:0] r_step;
  logic          q_bit;

  // The working remainder always stays below the divisor, so WD bits hold it;
  // only the trial value needs the extra bit for the compare.
  always_comb begin
    t_step = {r_work, n_work[WN-1]};
    r_step = t_step[WD-1:0];
    q_bit  = 1'b0;
    if (t_step >= {1'b0, d_reg}) begin
      r_step = t_step[WD-1:0] - d_reg;
      q_bit  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (divisor != '0) ? CALC : DONE;
        end
      end
      CALC: begin
        if (cnt == '0) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == CALC);
    done = (state == DONE);
  end

  // Dividend bits shift out of the top of n_work while quotient bits shift in at the bottom.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      n_work    <= '0;
      d_reg     <= '0;
      r_work    <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            n_work <= dividend;
            d_reg  <= divisor;
            r_work <= '0;
            cnt    <= CW'(WN - 1);
            if (divisor == '0) begin
              quotient  <= '1;
              remainder <= '0;
              div_zero  <= 1'b1;
            end else begin
              div_zero  <= 1'b0;
            end
          end
        end
        CALC: begin
          r_work <= r_step;
          n_work <= {n_work[WN-2:0], q_bit};
          cnt    <= cnt - 1'b1;
          if (cnt == '0) begin
            quotient  <= {n_work[WN-2:0], q_bit};
            remainder <= r_step;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sequential_divider.sv
// Randomized and exhaustive checks of sequential_divider against plain-arithmetic division.
module tb_sequential_divider;

  localparam int WN = 8;
  localparam int WD = 4;
  localparam int MAX_WAIT = 40;

  logic          clk;
  logic          reset_n;
  logic          start;
  logic [WN-1:0] dividend;
  logic [WD-1:0] divisor;
  logic          busy;
  logic          done;
  logic [WN-1:0] quotient;
  logic [WD-1:0] remainder;
  logic          div_zero;

  int n_checks;
  int n_fail;

  sequential_divider #(.WN(WN), .WD(WD)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Issue one division; glitch_at >= 0 pulses start again with other operands mid-calculation.
  task automatic run_div(input int n, input int d, input int glitch_at,
                         output int q, output int r, output int dz, output int lat);
    @(negedge clk);
    dividend = WN'(n);
    divisor  = WD'(d);
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    dividend = WN'($urandom);
    divisor  = WD'($urandom);
    lat = 0;
    while (done !== 1'b1 && lat < MAX_WAIT) begin
      if (lat == glitch_at) begin
        start    = 1'b1;
        dividend = WN'($urandom);
        divisor  = WD'($urandom_range(1, 15));
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    if (lat >= MAX_WAIT) check_val("done_timeout", lat, WN);
    q  = int'(quotient);
    r  = int'(remainder);
    dz = int'(div_zero);
  endtask

  task automatic check_ref(input string tag, input int n, input int d,
                           input int q, input int r, input int dz);
    int eq, er, ez;
    if (d == 0) begin
      eq = (1 << WN) - 1; er = 0; ez = 1;
    end else begin
      eq = n / d; er = n % d; ez = 0;
    end
    check_val({tag, "_q"}, q, eq);
    check_val({tag, "_r"}, r, er);
    check_val({tag, "_dz"}, dz, ez);
  endtask

  initial begin
    int q, r, dz, lat, n, d;
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #2;
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_done", int'(done), 0);
    check_val("rst_q", int'(quotient), 0);
    check_val("rst_r", int'(remainder), 0);
    check_val("rst_dz", int'(div_zero), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // T1: latency and basic result
    run_div(143, 11, -1, q, r, dz, lat);
    check_val("t1_lat", lat, WN);
    check_ref("t1", 143, 11, q, r, dz);
    @(negedge clk);
    check_val("t1_done_pulse", int'(done), 0);
    check_val("t1_idle_busy", int'(busy), 0);

    // T2: several operand patterns; results hold across idle cycles
    run_div(200, 7, -1, q, r, dz, lat);
    check_ref("t2a", 200, 7, q, r, dz);
    repeat (3) @(negedge clk);
    check_val("t2a_hold_q", int'(quotient), 28);
    check_val("t2a_hold_r", int'(remainder), 4);
    run_div(255, 1, -1, q, r, dz, lat);
    check_ref("t2b", 255, 1, q, r, dz);
    run_div(225, 15, -1, q, r, dz, lat);
    check_ref("t2c", 225, 15, q, r, dz);

    // T3: dividend smaller than divisor, then divide by zero, then recovery
    run_div(5, 9, -1, q, r, dz, lat);
    check_ref("t3a", 5, 9, q, r, dz);
    run_div(100, 0, -1, q, r, dz, lat);
    check_val("t3b_lat", lat, 0);
    check_ref("t3b", 100, 0, q, r, dz);
    @(negedge clk);
    check_val("t3b_done_pulse", int'(done), 0);
    check_val("t3b_dz_hold", int'(div_zero), 1);
    run_div(77, 6, -1, q, r, dz, lat);
    check_ref("t3c", 77, 6, q, r, dz);

    // T4: start during calculation is ignored, not queued
    run_div(143, 11, 3, q, r, dz, lat);
    check_val("t4_lat", lat, WN);
    check_ref("t4", 143, 11, q, r, dz);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("t4_no_requeue_busy", int'(busy), 0);
      check_val("t4_no_requeue_done", int'(done), 0);
    end

    // T5: reset in the middle of a calculation
    @(negedge clk);
    dividend = 8'd143;
    divisor  = 4'd11;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_val("t5_busy", int'(busy), 0);
    check_val("t5_done", int'(done), 0);
    check_val("t5_q", int'(quotient), 0);
    check_val("t5_r", int'(remainder), 0);
    repeat (2) begin
      @(negedge clk);
      check_val("t5_hold_done", int'(done), 0);
    end
    reset_n = 1'b1;
    for (int i = 0; i < WN + 2; i++) begin
      @(negedge clk);
      check_val("t5_no_done", int'(done), 0);
    end
    run_div(143, 11, -1, q, r, dz, lat);
    check_ref("t5_after", 143, 11, q, r, dz);

    // Randomized operands against the reference model
    for (int i = 0; i < 200; i++) begin
      n = int'($urandom_range(0, (1 << WN) - 1));
      d = int'($urandom_range(0, (1 << WD) - 1));
      run_div(n, d, -1, q, r, dz, lat);
      check_ref("rand", n, d, q, r, dz);
      check_val("rand_lat", lat, (d == 0) ? 0 : WN);
    end

    // T6: every operand pair, back to back
    for (int ni = 0; ni < (1 << WN); ni++) begin
      for (int di = 0; di < (1 << WD); di++) begin
        run_div(ni, di, -1, q, r, dz, lat);
        if (di == 0) begin
          check_val("ex_dz_q", q, (1 << WN) - 1);
          check_val("ex_dz_r", r, 0);
          check_val("ex_dz_flag", dz, 1);
        end else begin
          check_val("ex_inv", q * di + r, ni);
          check_val("ex_rlt", int'(r < di), 1);
          check_val("ex_flag", dz, 0);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
